// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_RESP
    } state_e;

    // RISC-V funct3 width/sign codes (loads and stores share encodings)
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Right-aligned byte masks; the RAM shifts them by the address
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic f3_reserved(input logic [2:0] f);
        return (f == 3'b011) || (f == 3'b110) || (f == 3'b111);
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f);
        case (f)
            F3_SB:   return MASK_B;
            F3_SH:   return MASK_H;
            F3_SW:   return MASK_W;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// lsu_load_fmt: combinational load result formatting (sign/zero extension).
module lsu_load_fmt
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [31:0] raw_i,
    output logic [31:0] rdata_o
);

    // Raw data arrives already shifted to the addressed byte
    always_comb begin
        rdata_o = 32'd0;
        case (funct3_i)
            F3_LB:   rdata_o = {{24{raw_i[7]}}, raw_i[7:0]};
            F3_LBU:  rdata_o = {24'd0, raw_i[7:0]};
            F3_LH:   rdata_o = {{16{raw_i[15]}}, raw_i[15:0]};
            F3_LHU:  rdata_o = {16'd0, raw_i[15:0]};
            F3_LW:   rdata_o = raw_i;
            default: rdata_o = 32'd0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// lsu: single-outstanding load/store unit between CPU and RAM.
// Optional feature: define LSU_MISALIGN_TRAP_EN to fault misaligned
// halfword/word accesses instead of issuing them to the RAM.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_valid,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_wrmask,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rd_valid,
    input  logic        i_mem_wr_valid,
    input  logic [31:0] i_mem_rdata
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e      state_q;
    logic        ready_q, valid_q, fault_q, mem_rd_q, mem_wr_q;
    logic [31:0] rdata_q;
    logic        we_q, bad_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  mask_q;
    logic [7:0]  cnt_q, cnt_d;
    logic        bad_d, done;
    logic [31:0] fmt_rdata;

    // Decide at capture time whether the request takes the immediate-fault path
    always_comb begin
        bad_d = f3_reserved(i_funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        if (i_funct3[1:0] == 2'b01 && i_addr[0])
            bad_d = 1'b1;
        if (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00)
            bad_d = 1'b1;
`endif
    end

    // Completion only counts when the strobe matches the access type
    always_comb begin
        done  = we_q ? i_mem_wr_valid : i_mem_rd_valid;
        cnt_d = cnt_q + 8'd1;
    end

    lsu_load_fmt u_fmt (
        .funct3_i (f3_q),
        .raw_i    (i_mem_rdata),
        .rdata_o  (fmt_rdata)
    );

    // Request FSM; all outputs are registered so reset holds every one at 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'd0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            we_q     <= 1'b0;
            bad_q    <= 1'b0;
            f3_q     <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            mask_q   <= 4'd0;
            cnt_q    <= 8'd0;
        end else begin
            valid_q  <= 1'b0;
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_valid && ready_q) begin
                        we_q     <= i_we;
                        f3_q     <= i_funct3;
                        addr_q   <= i_addr;
                        wdata_q  <= i_wdata;
                        mask_q   <= i_we ? store_mask(i_funct3) : 4'd0;
                        bad_q    <= bad_d;
                        cnt_q    <= 8'd0;
                        // strobes are registered so they are high exactly in ACCESS
                        mem_rd_q <= !i_we && !bad_d;
                        mem_wr_q <= i_we && !bad_d;
                        ready_q  <= 1'b0;
                        state_q  <= S_ACCESS;
                    end else begin
                        ready_q  <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    if (bad_q) begin
                        // faulted request: no strobe was issued, skip the wait
                        valid_q <= 1'b1;
                        fault_q <= 1'b1;
                        rdata_q <= 32'd0;
                        state_q <= S_RESP;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (done) begin
                        valid_q <= 1'b1;
                        fault_q <= 1'b0;
                        rdata_q <= we_q ? 32'd0 : fmt_rdata;
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == TMO) begin
                            valid_q <= 1'b1;
                            fault_q <= 1'b1;
                            rdata_q <= 32'd0;
                            state_q <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    fault_q <= 1'b0;
                    rdata_q <= 32'd0;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = valid_q;
    assign o_fault      = fault_q;
    assign o_rdata      = rdata_q;
    assign o_mem_rd     = mem_rd_q;
    assign o_mem_wr     = mem_wr_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wrmask = mask_q;
    assign o_mem_wdata  = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: directed scoreboard bench for lsu with a small byte RAM model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0, i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_addr = 32'd0, i_wdata = 32'd0;
    logic        o_ready, o_valid, o_fault, o_mem_rd, o_mem_wr;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_wrmask;
    logic        i_mem_rd_valid, i_mem_wr_valid;
    logic [31:0] i_mem_rdata;

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_valid(o_valid), .o_rdata(o_rdata), .o_fault(o_fault),
        .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_mem_addr(o_mem_addr),
        .o_mem_wrmask(o_mem_wrmask), .o_mem_wdata(o_mem_wdata),
        .i_mem_rd_valid(i_mem_rd_valid), .i_mem_wr_valid(i_mem_wr_valid),
        .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- RAM model: 256 bytes mapped at 0x00..0xFF ----------------
    logic [7:0] mem [0:255];
    logic       mem_init = 1'b1;
    logic       ram_hold = 1'b0;
    logic       force_rd = 1'b0;
    logic       ram_rd_v, ram_wr_v;
    logic       mapped;

    assign mapped         = (o_mem_addr < 32'd256);
    assign i_mem_rd_valid = ram_rd_v | force_rd;
    assign i_mem_wr_valid = ram_wr_v;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
            mem[8'h41] <= 8'h80;
        end else if (o_mem_wr && mapped && !ram_hold) begin
            for (int k = 0; k < 4; k++)
                if (o_mem_wrmask[k] && (int'(o_mem_addr[1:0]) + k) < 4)
                    mem[int'(o_mem_addr[7:0]) + k] <= o_mem_wdata[8*k +: 8];
        end
        ram_rd_v <= o_mem_rd && mapped && !ram_hold;
        ram_wr_v <= o_mem_wr && mapped && !ram_hold;
    end

    always_comb begin
        logic [7:0]  b;
        logic [31:0] w;
        b = {o_mem_addr[7:2], 2'b00};
        w = {mem[b + 8'd3], mem[b + 8'd2], mem[b + 8'd1], mem[b]};
        i_mem_rdata = mapped ? (w >> {o_mem_addr[1:0], 3'b000}) : 32'd0;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] rd;
        logic        f;
        int          lat;
        int          acc;
    } exp_t;
    exp_t q[$];

    int tests = 0, fails = 0;
    int rd_pulses = 0, wr_pulses = 0;
    logic [3:0]  wr_mask_seen;
    logic [31:0] wr_data_seen;
    int last_acc = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: compare every response against the oldest expectation
    always @(negedge clk) begin
        if (o_mem_rd) rd_pulses++;
        if (o_mem_wr) begin
            wr_pulses++;
            wr_mask_seen = o_mem_wrmask;
            wr_data_seen = o_mem_wdata;
        end
        if (o_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got o_valid=1 expected no response (cyc %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rdata", o_rdata, e.rd);
                check("fault", 32'(o_fault), 32'(e.f));
                check("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_f,
                         input int lat, input bit keep, input bit push);
        int n;
        exp_t e;
        @(negedge clk);
        i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got o_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (push) begin
            e.rd = exp_rd; e.f = exp_f; e.lat = lat; e.acc = cyc;
            q.push_back(e);
        end
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending responses expected 0", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    task automatic clr_cnt();
        rd_pulses = 0;
        wr_pulses = 0;
        wr_mask_seen = 4'd0;
        wr_data_seen = 32'd0;
    endtask

    initial begin
        int a0;
        // reset state
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        check("rst_ready", 32'(o_ready), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_strobes", {30'd0, o_mem_rd, o_mem_wr}, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_mask_wdata", {o_mem_wrmask, o_mem_wdata[27:0]}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(o_ready), 1);

        // LB sign-extends byte 0x80
        clr_cnt();
        issue(1'b0, 3'b000, 32'h41, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b0, 1'b1);
        drain();
        check("lb_rd_pulses", 32'(rd_pulses), 1);
        // LBU zero-extends
        issue(1'b0, 3'b100, 32'h41, 32'h0, 32'h00000080, 1'b0, 3, 1'b0, 1'b1);
        drain();

        // SH store then read back
        clr_cnt();
        issue(1'b1, 3'b001, 32'h42, 32'h1234ABCD, 32'h0, 1'b0, 3, 1'b0, 1'b1);
        drain();
        check("sh_wr_pulses", 32'(wr_pulses), 1);
        check("sh_rd_pulses", 32'(rd_pulses), 0);
        check("sh_mask", 32'(wr_mask_seen), 32'h3);
        check("sh_wdata", wr_data_seen, 32'h1234ABCD);
        issue(1'b0, 3'b101, 32'h42, 32'h0, 32'h0000ABCD, 1'b0, 3, 1'b0, 1'b1);
        drain();
        issue(1'b0, 3'b001, 32'h42, 32'h0, 32'hFFFFABCD, 1'b0, 3, 1'b0, 1'b1);
        drain();
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'hABCD8040, 1'b0, 3, 1'b0, 1'b1);
        drain();

        // unmapped load times out after 4 WAIT cycles
        clr_cnt();
        issue(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 6, 1'b0, 1'b1);
        drain();
        check("tmo_rd_pulses", 32'(rd_pulses), 1);

        // reserved funct3 faults immediately with no strobe
        clr_cnt();
        issue(1'b0, 3'b011, 32'h40, 32'h0, 32'h0, 1'b1, 2, 1'b0, 1'b1);
        drain();
        check("rsv_strobes", 32'(rd_pulses + wr_pulses), 0);

        // misaligned word load
        clr_cnt();
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h0, 1'b1, 2, 1'b0, 1'b1);
        drain();
        check("mis_rd_pulses", 32'(rd_pulses), 0);
`else
        issue(1'b0, 3'b010, 32'h42, 32'h0, 32'h0000ABCD, 1'b0, 3, 1'b0, 1'b1);
        drain();
        check("mis_rd_pulses", 32'(rd_pulses), 1);
`endif

        // reset while waiting; late completion must be ignored
        ram_hold = 1'b1;
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(o_ready), 0);
        check("midrst_addr", o_mem_addr, 0);
        check("midrst_out", {29'd0, o_valid, o_mem_rd, o_fault}, 0);
        @(negedge clk);
        rst = 1'b0;
        ram_hold = 1'b0;
        force_rd = 1'b1;
        @(negedge clk);
        force_rd = 1'b0;
        check("postrst_ready", 32'(o_ready), 1);
        check("late_valid", 32'(o_valid), 0);
        @(negedge clk);
        check("late_valid2", 32'(o_valid), 0);
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'hABCD8040, 1'b0, 3, 1'b0, 1'b1);
        drain();

        // back-to-back requests with i_valid held high
        issue(1'b0, 3'b010, 32'h40, 32'h0, 32'hABCD8040, 1'b0, 3, 1'b1, 1'b1);
        a0 = last_acc;
        issue(1'b0, 3'b010, 32'h44, 32'h0, 32'h47464544, 1'b0, 3, 1'b1, 1'b1);
        check("b2b_gap1", 32'(last_acc - a0), 4);
        a0 = last_acc;
        issue(1'b0, 3'b010, 32'h48, 32'h0, 32'h4B4A4948, 1'b0, 3, 1'b0, 1'b1);
        check("b2b_gap2", 32'(last_acc - a0), 4);
        drain();
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
